// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types, channel indices and helpers for the button conditioner
package btn_pkg;

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        DEB_PRESS = 5'b00010,
        PRESSED   = 5'b00100,
        HELD      = 5'b01000,
        DEB_REL   = 5'b10000
    } deb_state_t;

    localparam int BTN_R   = 0;
    localparam int BTN_L   = 1;
    localparam int BTN_U   = 2;
    localparam int BTN_D   = 3;
    localparam int BTN_C   = 4;
    localparam int BTN_CHK = 5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_scen_debouncer_if.sv
// rtl/btn_scen_debouncer_if.sv - raw button levels in, debounced level/pulse outputs
interface btn_scen_debouncer_if #(
    parameter int N_BTN = 6
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_db;
    logic [N_BTN-1:0] btn_scen;
    logic [N_BTN-1:0] btn_mcen;
    logic             any_scen;

    modport master (output btn_raw, input btn_db, input btn_scen, input btn_mcen, input any_scen);
    modport slave  (input btn_raw, output btn_db, output btn_scen, output btn_mcen, output any_scen);
endinterface

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one channel: 2-flop sync, debounce FSM, optional repeat (AUTO_REPEAT_EN)
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 20000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic db,
    output logic scen,
    output logic mcen
);

    localparam int MAXP = max3(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          s;
    deb_state_t    state;
    logic [CW-1:0] cnt;

`ifdef AUTO_REPEAT_EN
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
    logic [CW-1:0] rcnt;
    logic          rep_on;
`else
    assign mcen = scen;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            db    <= 1'b0;
            scen  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rcnt   <= '0;
            rep_on <= 1'b0;
            mcen   <= 1'b0;
`endif
        end else begin
            sync1 <= raw;
            s     <= sync1;
            scen  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            mcen  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (s) state <= DEB_PRESS;
                end
                DEB_PRESS: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        scen  <= 1'b1;
                        db    <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        mcen   <= 1'b1;
                        rcnt   <= '0;
                        rep_on <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: state <= HELD;
                HELD: begin
                    if (!s) begin
                        state <= DEB_REL;
                        cnt   <= '0;
                    end
                end
                DEB_REL: begin
                    if (s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        db    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    db    <= 1'b0;
                end
            endcase
`ifdef AUTO_REPEAT_EN
            // Repeat count runs from PRESSED through an unbroken HELD; frozen in DEB_REL.
            if (state == PRESSED || (state == HELD && s)) begin
                if (!rep_on && rcnt == DLY_LAST) begin
                    mcen   <= 1'b1;
                    rcnt   <= '0;
                    rep_on <= 1'b1;
                end else if (rep_on && rcnt == PER_LAST) begin
                    mcen <= 1'b1;
                    rcnt <= '0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end else if (state == DEB_REL && s) begin
                rcnt   <= '0;
                rep_on <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/btn_scen_debouncer.sv
// rtl/btn_scen_debouncer.sv - N_BTN independent debounce channels; AUTO_REPEAT_EN enables repeat pulses
module btn_scen_debouncer #(
    parameter int N_BTN         = 6,
    parameter int DEB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 20000000
) (
    input  logic                Clk,
    input  logic                Reset,
    btn_scen_debouncer_if.slave bus
);

    logic [N_BTN-1:0] db;
    logic [N_BTN-1:0] scen;
    logic [N_BTN-1:0] mcen;

    for (genvar k = 0; k < N_BTN; k++) begin : g_ch
        btn_debounce_ch #(
            .DEB_CYCLES   (DEB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk   (Clk),
            .resetn(Reset),
            .raw   (bus.btn_raw[k]),
            .db    (db[k]),
            .scen  (scen[k]),
            .mcen  (mcen[k])
        );
    end

    assign bus.btn_db   = db;
    assign bus.btn_scen = scen;
    assign bus.btn_mcen = mcen;
    assign bus.any_scen = |scen;

endmodule

// File: tb/tb_btn_scen_debouncer.sv
// tb/tb_btn_scen_debouncer.sv - scoreboard bench for btn_scen_debouncer (DEB=4, DELAY=10, PERIOD=3)
module tb_btn_scen_debouncer;
    import btn_pkg::*;

    localparam int NB = 6;

    typedef struct {
        int            cyc;
        logic [NB-1:0] bits;
        logic          any;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ev_t exp_scen[$];
    ev_t obs_scen[$];
    ev_t exp_mcen[$];
    ev_t obs_mcen[$];

    always #5 clk = ~clk;

    btn_scen_debouncer_if #(.N_BTN(NB)) bus ();

    btn_scen_debouncer #(
        .N_BTN        (NB),
        .DEB_CYCLES   (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .Clk  (clk),
        .Reset(reset),
        .bus  (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.btn_scen != '0 || bus.any_scen)
            obs_scen.push_back('{cyc, bus.btn_scen, bus.any_scen});
        if (bus.btn_mcen != '0)
            obs_mcen.push_back('{cyc, bus.btn_mcen, 1'b0});
    end

    function automatic logic [NB-1:0] bit_of(input int k);
        logic [NB-1:0] m;
        m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(3);
        checks += 4;
        if (bus.btn_db !== '0)   begin errors++; $display("FAIL reset_db got %b want 0", bus.btn_db); end
        if (bus.btn_scen !== '0) begin errors++; $display("FAIL reset_scen got %b want 0", bus.btn_scen); end
        if (bus.btn_mcen !== '0) begin errors++; $display("FAIL reset_mcen got %b want 0", bus.btn_mcen); end
        if (bus.any_scen !== 1'b0) begin errors++; $display("FAIL reset_any got %b want 0", bus.any_scen); end
        reset = 1'b1;
        step(2);
        obs_scen.delete();
    endtask

    task automatic test_clean_press();
        int  t0;
        ev_t e, o;
        t0 = cyc;
        bus.btn_raw[BTN_R] = 1'b1;
        exp_scen.push_back('{t0 + 7, bit_of(BTN_R), 1'b1});
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if (bus.btn_db[BTN_R] !== (cyc >= t0 + 7)) begin
                errors++;
                $display("FAIL clean_db cyc %0d got %b want %b", cyc - t0, bus.btn_db[BTN_R], (cyc >= t0 + 7));
            end
        end
        while (exp_scen.size() > 0) begin
            e = exp_scen.pop_front();
            checks++;
            if (obs_scen.size() == 0) begin
                errors++; $display("FAIL clean_scen missing pulse want cyc %0d", e.cyc);
            end else begin
                o = obs_scen.pop_front();
                if (o.cyc !== e.cyc || o.bits !== e.bits || o.any !== e.any) begin
                    errors++;
                    $display("FAIL clean_scen got cyc %0d bits %b any %b want cyc %0d bits %b any %b", o.cyc, o.bits, o.any, e.cyc, e.bits, e.any);
                end
            end
        end
        checks++;
        if (obs_scen.size() != 0) begin errors++; $display("FAIL clean_extra got %0d extra pulses want 0", obs_scen.size()); end
        obs_scen.delete();
    endtask

    task automatic test_release_bounce();
        int t2;
        bus.btn_raw[BTN_R] = 1'b0;
        step(2);
        bus.btn_raw[BTN_R] = 1'b1;
        step(1);
        bus.btn_raw[BTN_R] = 1'b0;
        t2 = cyc;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if (bus.btn_db[BTN_R] !== (cyc < t2 + 7)) begin
                errors++;
                $display("FAIL release_db cyc %0d got %b want %b", cyc - t2, bus.btn_db[BTN_R], (cyc < t2 + 7));
            end
        end
        checks++;
        if (obs_scen.size() != 0) begin errors++; $display("FAIL release_scen got %0d pulses want 0", obs_scen.size()); end
        obs_scen.delete();
    endtask

    task automatic test_bounce();
        int  t4;
        ev_t e, o;
        bus.btn_raw[BTN_U] = 1'b1;
        step(3);
        bus.btn_raw[BTN_U] = 1'b0;
        step(1);
        bus.btn_raw[BTN_U] = 1'b1;
        t4 = cyc;
        exp_scen.push_back('{t4 + 7, bit_of(BTN_U), 1'b1});
        step(12);
        while (exp_scen.size() > 0) begin
            e = exp_scen.pop_front();
            checks++;
            if (obs_scen.size() == 0) begin
                errors++; $display("FAIL bounce_scen missing pulse want cyc %0d", e.cyc);
            end else begin
                o = obs_scen.pop_front();
                if (o.cyc !== e.cyc || o.bits !== e.bits || o.any !== e.any) begin
                    errors++;
                    $display("FAIL bounce_scen got cyc %0d bits %b want cyc %0d bits %b", o.cyc, o.bits, e.cyc, e.bits);
                end
            end
        end
        checks++;
        if (obs_scen.size() != 0) begin errors++; $display("FAIL bounce_extra got %0d extra pulses want 0", obs_scen.size()); end
        obs_scen.delete();
        bus.btn_raw[BTN_U] = 1'b0;
        step(8);
    endtask

    task automatic test_simultaneous();
        int  t;
        int  any_cnt;
        ev_t e, o;
        t = cyc;
        bus.btn_raw[BTN_L] = 1'b1;
        bus.btn_raw[BTN_C] = 1'b1;
        exp_scen.push_back('{t + 7, bit_of(BTN_L) | bit_of(BTN_C), 1'b1});
        step(12);
        any_cnt = 0;
        foreach (obs_scen[i]) if (obs_scen[i].any === 1'b1) any_cnt++;
        checks++;
        if (any_cnt != 1) begin errors++; $display("FAIL simul_any got %0d cycles want 1", any_cnt); end
        while (exp_scen.size() > 0) begin
            e = exp_scen.pop_front();
            checks++;
            if (obs_scen.size() == 0) begin
                errors++; $display("FAIL simul_scen missing pulse want cyc %0d", e.cyc);
            end else begin
                o = obs_scen.pop_front();
                if (o.cyc !== e.cyc || o.bits !== e.bits || o.any !== e.any) begin
                    errors++;
                    $display("FAIL simul_scen got cyc %0d bits %b any %b want cyc %0d bits %b any %b", o.cyc, o.bits, o.any, e.cyc, e.bits, e.any);
                end
            end
        end
        checks++;
        if (obs_scen.size() != 0) begin errors++; $display("FAIL simul_extra got %0d extra pulses want 0", obs_scen.size()); end
        obs_scen.delete();
        bus.btn_raw[BTN_L] = 1'b0;
        bus.btn_raw[BTN_C] = 1'b0;
        step(8);
    endtask

    task automatic test_auto_repeat();
        int  t, p;
        ev_t e, o;
        obs_mcen.delete();
        obs_scen.delete();
        t = cyc;
        p = t + 7;
        bus.btn_raw[BTN_CHK] = 1'b1;
        exp_scen.push_back('{p, bit_of(BTN_CHK), 1'b1});
        exp_mcen.push_back('{p, bit_of(BTN_CHK), 1'b0});
`ifdef AUTO_REPEAT_EN
        for (int k = 10; k <= 28; k += 3)
            exp_mcen.push_back('{p + k, bit_of(BTN_CHK), 1'b0});
`endif
        step(35);
        bus.btn_raw[BTN_CHK] = 1'b0;
        step(10);
        while (exp_mcen.size() > 0) begin
            e = exp_mcen.pop_front();
            checks++;
            if (obs_mcen.size() == 0) begin
                errors++; $display("FAIL repeat_mcen missing pulse want +%0d", e.cyc - p);
            end else begin
                o = obs_mcen.pop_front();
                if (o.cyc !== e.cyc || o.bits !== e.bits) begin
                    errors++;
                    $display("FAIL repeat_mcen got +%0d bits %b want +%0d bits %b", o.cyc - p, o.bits, e.cyc - p, e.bits);
                end
            end
        end
        checks++;
        if (obs_mcen.size() != 0) begin errors++; $display("FAIL repeat_extra got %0d extra mcen pulses want 0", obs_mcen.size()); end
        while (exp_scen.size() > 0) begin
            e = exp_scen.pop_front();
            checks++;
            if (obs_scen.size() == 0) begin
                errors++; $display("FAIL repeat_scen missing pulse want cyc %0d", e.cyc);
            end else begin
                o = obs_scen.pop_front();
                if (o.cyc !== e.cyc || o.bits !== e.bits) begin
                    errors++;
                    $display("FAIL repeat_scen got cyc %0d bits %b want cyc %0d bits %b", o.cyc, o.bits, e.cyc, e.bits);
                end
            end
        end
        checks++;
        if (obs_scen.size() != 0) begin errors++; $display("FAIL repeat_scen_extra got %0d extra pulses want 0", obs_scen.size()); end
        obs_scen.delete();
        obs_mcen.delete();
    endtask

    task automatic test_reset_mid_press();
        int  t, tr;
        ev_t e, o;
        t = cyc;
        bus.btn_raw[BTN_D] = 1'b1;
        exp_scen.push_back('{t + 7, bit_of(BTN_D), 1'b1});
        step(12);
        reset = 1'b0;
        tr = cyc;
        step(1);
        checks += 4;
        if (bus.btn_db !== '0)   begin errors++; $display("FAIL midrst_db got %b want 0", bus.btn_db); end
        if (bus.btn_scen !== '0) begin errors++; $display("FAIL midrst_scen got %b want 0", bus.btn_scen); end
        if (bus.btn_mcen !== '0) begin errors++; $display("FAIL midrst_mcen got %b want 0", bus.btn_mcen); end
        if (bus.any_scen !== 1'b0) begin errors++; $display("FAIL midrst_any got %b want 0", bus.any_scen); end
        reset = 1'b1;
        exp_scen.push_back('{tr + 8, bit_of(BTN_D), 1'b1});
        step(12);
        while (exp_scen.size() > 0) begin
            e = exp_scen.pop_front();
            checks++;
            if (obs_scen.size() == 0) begin
                errors++; $display("FAIL midrst_pulse missing pulse want cyc %0d", e.cyc);
            end else begin
                o = obs_scen.pop_front();
                if (o.cyc !== e.cyc || o.bits !== e.bits) begin
                    errors++;
                    $display("FAIL midrst_pulse got cyc %0d bits %b want cyc %0d bits %b", o.cyc, o.bits, e.cyc, e.bits);
                end
            end
        end
        checks++;
        if (obs_scen.size() != 0) begin errors++; $display("FAIL midrst_extra got %0d extra pulses want 0", obs_scen.size()); end
        obs_scen.delete();
        bus.btn_raw[BTN_D] = 1'b0;
        step(8);
    endtask

    initial begin
        bus.btn_raw = '0;
        test_reset();
        test_clean_press();
        test_release_bounce();
        test_bounce();
        test_simultaneous();
        test_auto_repeat();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
